// File: rtl/mem0_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem0_pkg                                                                 |
// | Shared widths, bus layouts, size encodings and FSM states for the        |
// | TinyCPU MEM0 stage.                                                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem0_pkg;

  localparam int REG_W            = 32;
  localparam int REG_ADDR_BUS_W   = 5;
  localparam int EX2MEM0_BUS_SIZE = 108;
  localparam int MEM02WB_BUS_SIZE = 70;

  // Access size encodings carried in mem_ctl.size
  localparam logic [2:0] SIZE_BYTE = 3'd4;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef struct packed {
    logic       load;
    logic       store;
    logic       ld_sign;
    logic [2:0] size;
  } mem_ctl_t;

  // Field order matches the EX stage register, MSB first
  typedef struct packed {
    mem_ctl_t                  ctl;
    logic [REG_W-1:0]          st_data;
    logic [REG_W-1:0]          exe_result;
    logic [REG_ADDR_BUS_W-1:0] rd_addr;
    logic                      rd_we;
    logic [REG_W-1:0]          pc;
  } ex2mem0_bus_t;

  // Half accesses need a[0]==0, word accesses need a[1:0]==0; bytes never fault
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SIZE_HALF: return lo[0];
      SIZE_WORD: return (lo != 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem0_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem0_align                                                               |
// | Combinational store-lane steering (byte strobes + replicated write data) |
// | and load-lane extraction with sign/zero extension.                       |
// | Ports: size_i/addr_lo_i select the lane, ld_sign_i selects extension,    |
// |        st_data_i -> wstrb_o/wdata_o, rdata_i -> ld_data_o.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem0_align
  import mem0_pkg::*;
(
  input  logic [2:0]       size_i,
  input  logic [1:0]       addr_lo_i,
  input  logic             ld_sign_i,
  input  logic [REG_W-1:0] st_data_i,
  input  logic [REG_W-1:0] rdata_i,
  output logic [3:0]       wstrb_o,
  output logic [REG_W-1:0] wdata_o,
  output logic [REG_W-1:0] ld_data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    // Half lane uses a[1] only; a[0] is ignored here
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    wstrb_o   = 4'b1111;
    wdata_o   = st_data_i;
    ld_data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        wstrb_o   = 4'b0001 << addr_lo_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{ld_sign_i & byte_v[7]}}, byte_v};
      end
      SIZE_HALF: begin
        wstrb_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = {{16{ld_sign_i & half_v[15]}}, half_v};
      end
      default: begin
        wstrb_o   = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = rdata_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem0.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem0                                                                     |
// | First memory stage: runs one req/resp transaction on the data SRAM port  |
// | per load/store, then presents the MEM->WB bus and forwarding info to ID. |
// | Ports: ex2mem0_bus_ri (EX register), ctl_mem0_* (pipeline control),      |
// |        forward_mem02id_* (to ID), mem02wb_bus_o (to WB), data_* (SRAM).  |
// | Option: MEM0_ALIGN_CHECK_EN adds ctl_mem0_ale_o and traps misaligned     |
// |         half/word accesses without issuing a request.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem0
  import mem0_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [EX2MEM0_BUS_SIZE-1:0] ex2mem0_bus_ri,
  input  logic                        ctl_mem0_valid_i,
  input  logic                        ctl_mem0_adv_i,
  output logic                        ctl_mem0_over_o,
  output logic [REG_ADDR_BUS_W-1:0]   ctl_mem0_dest_o,
  output logic [REG_W-1:0]            ctl_mem0_pc_o,
  output logic [REG_W-1:0]            forward_mem02id_data_o,
  output logic                        forward_mem02id_valid_o,
  output logic [MEM02WB_BUS_SIZE-1:0] mem02wb_bus_o,
  output logic                        data_req_o,
  output logic                        data_we_o,
  output logic [3:0]                  data_wstrb_o,
  output logic [REG_W-1:0]            data_addr_o,
  output logic [REG_W-1:0]            data_wdata_o,
  input  logic                        data_addr_ok_i,
  input  logic                        data_data_ok_i,
`ifdef MEM0_ALIGN_CHECK_EN
  output logic                        ctl_mem0_ale_o,
`endif
  input  logic [REG_W-1:0]            data_rdata_i
);

  ex2mem0_bus_t     bus;
  state_e           state_q, state_d;
  logic [REG_W-1:0] ld_data_q, ld_data_d;
  logic [REG_W-1:0] ld_ext;
  logic [REG_W-1:0] result;
  logic             is_mem;
  logic             misaligned;
  logic             rd_we;

  assign bus    = ex2mem0_bus_ri;
  assign is_mem = bus.ctl.load | bus.ctl.store;

`ifdef MEM0_ALIGN_CHECK_EN
  assign misaligned     = is_misaligned(bus.ctl.size, bus.exe_result[1:0]);
  assign ctl_mem0_ale_o = ctl_mem0_valid_i & is_mem & misaligned;
`else
  assign misaligned     = 1'b0;
`endif

  mem0_align u_align (
    .size_i    (bus.ctl.size),
    .addr_lo_i (bus.exe_result[1:0]),
    .ld_sign_i (bus.ctl.ld_sign),
    .st_data_i (bus.st_data),
    .rdata_i   (data_rdata_i),
    .wstrb_o   (data_wstrb_o),
    .wdata_o   (data_wdata_o),
    .ld_data_o (ld_ext)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_data_q <= ld_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_data_d = ld_data_q;
    case (state_q)
      ST_IDLE: begin
        // data_ok here is a leftover from before a reset and is ignored
        if (ctl_mem0_valid_i && is_mem) state_d = misaligned ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        // Once accepted the response must still be consumed, even if flushed now
        if (data_addr_ok_i)         state_d = ST_WAIT;
        else if (!ctl_mem0_valid_i) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (data_data_ok_i) begin
          state_d   = ctl_mem0_valid_i ? ST_DONE : ST_IDLE;
          ld_data_d = ld_ext;
        end else if (!ctl_mem0_valid_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (ctl_mem0_adv_i || !ctl_mem0_valid_i) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (data_data_ok_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    result          = bus.exe_result;
    ctl_mem0_over_o = 1'b0;
    case (state_q)
      ST_IDLE: ctl_mem0_over_o = ctl_mem0_valid_i & ~is_mem;
      ST_DONE: begin
        ctl_mem0_over_o = ctl_mem0_valid_i;
        if (misaligned)        result = '0;
        else if (bus.ctl.load) result = ld_data_q;
      end
      default: ctl_mem0_over_o = 1'b0;
    endcase
  end

  assign rd_we = bus.rd_we & ~(is_mem & misaligned);

  assign data_req_o  = (state_q == ST_REQ);
  assign data_we_o   = bus.ctl.store;
  assign data_addr_o = {bus.exe_result[REG_W-1:2], 2'b00};

  assign ctl_mem0_dest_o         = bus.rd_addr & {REG_ADDR_BUS_W{ctl_mem0_valid_i}};
  assign ctl_mem0_pc_o           = bus.pc;
  assign forward_mem02id_data_o  = result & {REG_W{ctl_mem0_valid_i}};
  assign forward_mem02id_valid_o = ~bus.ctl.load | (state_q == ST_DONE);
  assign mem02wb_bus_o           = {result, bus.rd_addr, rd_we, bus.pc};

endmodule
`default_nettype wire

// File: tb/tb_mem0.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem0                                                                  |
// | Self-checking bench for mem0: directed scenarios plus randomized         |
// | load/store transactions checked against an arithmetic lane model.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [107:0] bus;
  logic         valid, adv, addr_ok, data_ok;
  logic [31:0]  rdata;
  logic         over, fwd_valid, req, we;
  logic [4:0]   dest;
  logic [31:0]  pc_o, fwd_data, addr, wdata;
  logic [69:0]  wb;
  logic [3:0]   wstrb;
`ifdef MEM0_ALIGN_CHECK_EN
  logic         ale;
`endif

  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem0 dut (
    .clk_i                   (clk),
    .rst_n_i                 (rst_n),
    .ex2mem0_bus_ri          (bus),
    .ctl_mem0_valid_i        (valid),
    .ctl_mem0_adv_i          (adv),
    .ctl_mem0_over_o         (over),
    .ctl_mem0_dest_o         (dest),
    .ctl_mem0_pc_o           (pc_o),
    .forward_mem02id_data_o  (fwd_data),
    .forward_mem02id_valid_o (fwd_valid),
    .mem02wb_bus_o           (wb),
    .data_req_o              (req),
    .data_we_o               (we),
    .data_wstrb_o            (wstrb),
    .data_addr_o             (addr),
    .data_wdata_o            (wdata),
    .data_addr_ok_i          (addr_ok),
    .data_data_ok_i          (data_ok),
`ifdef MEM0_ALIGN_CHECK_EN
    .ctl_mem0_ale_o          (ale),
`endif
    .data_rdata_i            (rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [107:0] mk_bus(input logic ld, input logic st, input logic sg,
                                          input logic [2:0] sz, input logic [31:0] sd,
                                          input logic [31:0] exe, input logic [4:0] rd,
                                          input logic rwe, input logic [31:0] pc);
    return {ld, st, sg, sz, sd, exe, rd, rwe, pc};
  endfunction

  // ---- reference model: lane arithmetic straight from the access rules ----
  function automatic logic [3:0] m_strb(input logic [2:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 3'd4) return 4'(1 << off);
    if (sz == 3'd2) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] sd);
    if (sz == 3'd4) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 3'd2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a,
                                         input logic sg, input logic [31:0] rd_val);
    logic [31:0] raw;
    int off = int'(a % 4);
    if (sz == 3'd4) begin
      raw = (rd_val >> (8 * off)) & 32'hFF;
      if (sg && raw >= 128) raw = raw - 256;
      return raw;
    end
    if (sz == 3'd2) begin
      raw = (rd_val >> (16 * (off / 2))) & 32'hFFFF;
      if (sg && raw >= 32768) raw = raw - 65536;
      return raw;
    end
    return rd_val;
  endfunction

  // One complete load/store transaction, starting with the stage in IDLE.
  task automatic do_mem(input string tag, input logic ld, input logic sg, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd_val,
                        input int a_dly, input int d_dly, input bit hold,
                        output logic [3:0] o_strb, output logic [31:0] o_wdata,
                        output logic [31:0] o_res);
    logic [4:0]  rd;
    logic [31:0] pc, exp_res;
    rd      = 5'($urandom_range(1, 31));
    pc      = $urandom;
    exp_res = ld ? m_load(sz, a, sg, rd_val) : a;
    o_strb  = '0;
    o_wdata = '0;
    bus     = mk_bus(ld, !ld, sg, sz, sd, a, rd, 1'b1, pc);
    valid = 1'b1; adv = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    #1;
    check({tag, "_c0_req"}, 32'(req), 0);
    check({tag, "_c0_over"}, 32'(over), 0);
    check({tag, "_c0_fwdv"}, 32'(fwd_valid), 32'(!ld));
    step();
    for (int i = 0; i <= a_dly; i++) begin
      addr_ok = (i == a_dly);
      data_ok = 1'($urandom_range(0, 1));  // stale responses must be ignored
      rdata   = $urandom;
      #1;
      check({tag, "_req"}, 32'(req), 1);
      check({tag, "_we"}, 32'(we), 32'(!ld));
      check({tag, "_addr"}, addr, a & 32'hFFFF_FFFC);
      check({tag, "_req_over"}, 32'(over), 0);
      if (!ld) begin
        check({tag, "_wstrb"}, 32'(wstrb), 32'(m_strb(sz, a)));
        check({tag, "_wdata"}, wdata, m_wdata(sz, sd));
      end
      o_strb  = wstrb;
      o_wdata = wdata;
      step();
    end
    addr_ok = 1'b0;
    for (int j = 0; j <= d_dly; j++) begin
      data_ok = (j == d_dly);
      rdata   = (j == d_dly) ? rd_val : $urandom;
      #1;
      check({tag, "_wait_req"}, 32'(req), 0);
      check({tag, "_wait_over"}, 32'(over), 0);
      check({tag, "_wait_fwdv"}, 32'(fwd_valid), 32'(!ld));
      step();
    end
    data_ok = 1'b0;
    rdata   = $urandom;
    #1;
    check({tag, "_done_over"}, 32'(over), 1);
    check({tag, "_done_res"}, wb[69:38], exp_res);
    check({tag, "_done_rd"}, 32'(wb[37:33]), 32'(rd));
    check({tag, "_done_rdwe"}, 32'(wb[32]), 1);
    check({tag, "_done_pc"}, wb[31:0], pc);
    check({tag, "_done_fwdv"}, 32'(fwd_valid), 1);
    check({tag, "_done_fwdd"}, fwd_data, exp_res);
    check({tag, "_done_dest"}, 32'(dest), 32'(rd));
    o_res = wb[69:38];
    if (hold) begin
      step();
      rdata = $urandom;
      #1;
      check({tag, "_hold_over"}, 32'(over), 1);
      check({tag, "_hold_res"}, wb[69:38], exp_res);
    end
    adv = 1'b1;
    step();
    adv = 1'b0; valid = 1'b0;
    #1;
    check({tag, "_after_over"}, 32'(over), 0);
  endtask

  initial begin : main
    logic [3:0]  s;
    logic [31:0] d, r;
    logic [2:0]  sz;

    // Reset state
    rst_n = 1'b0; bus = '0; valid = 1'b0; adv = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    step(); step();
    check("rst_req", 32'(req), 0);
    check("rst_over", 32'(over), 0);
    check("rst_dest", 32'(dest), 0);
    check("rst_fwdd", fwd_data, 0);
    check("rst_fwdv", 32'(fwd_valid), 1);
    rst_n = 1'b1;
    step();

    // ALU passthrough: result ready in the same cycle, no SRAM activity
    bus = mk_bus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h1234, 5'd7, 1'b1, 32'h400);
    valid = 1'b1;
    #1;
    check("alu_over", 32'(over), 1);
    check("alu_res", wb[69:38], 32'h1234);
    check("alu_req", 32'(req), 0);
    check("alu_fwdv", 32'(fwd_valid), 1);
    check("alu_fwdd", fwd_data, 32'h1234);
    check("alu_dest", 32'(dest), 7);
    check("alu_pc", pc_o, 32'h400);
    adv = 1'b1;
    step();
    adv = 1'b0;
    #1;
    check("alu_stays_idle", 32'(req), 0);
    valid = 1'b0;
    #1;
    check("novalid_over", 32'(over), 0);
    check("novalid_dest", 32'(dest), 0);
    check("novalid_fwdd", fwd_data, 0);

    // Signed byte load with minimum latency
    do_mem("sbyte", 1'b1, 1'b1, 3'd4, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0, 1'b0, s, d, r);
    check("sbyte_lit", r, 32'hFFFF_FF80);

    // Half store to the upper lane
    do_mem("hstore", 1'b0, 1'b0, 3'd2, 32'h2002, 32'hABCD_5678, 32'h0, 0, 1, 1'b1, s, d, r);
    check("hstore_strb_lit", 32'(s), 32'(4'b1100));
    check("hstore_wdata_lit", d, 32'h5678_5678);

    // Backpressure: addr_ok withheld for 4 cycles, request held stable
    do_mem("bp4", 1'b0, 1'b0, 3'd4, 32'h3001, 32'h1122_3344, 32'h0, 4, 2, 1'b0, s, d, r);

    // Backpressure then flush while still in REQ: request withdrawn
    bus = mk_bus(1'b0, 1'b1, 1'b0, 3'd4, 32'h1122_3344, 32'h3001, 5'd9, 1'b1, 32'h500);
    valid = 1'b1;
    #1;
    check("bpf_c0_req", 32'(req), 0);
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bpf_req", 32'(req), 1);
      check("bpf_addr", addr, 32'h3000);
      check("bpf_wstrb", 32'(wstrb), 32'(m_strb(3'd4, 32'h3001)));
      step();
    end
    valid = 1'b0;
    step();
    check("bpf_req_drop", 32'(req), 0);
    bus = mk_bus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'hCAFE, 5'd3, 1'b1, 32'h504);
    valid = 1'b1;
    #1;
    check("bpf_idle_over", 32'(over), 1);
    check("bpf_idle_res", wb[69:38], 32'hCAFE);
    valid = 1'b0;
    step();

    // Flush in WAIT: response is drained, a following load waits for it
    bus = mk_bus(1'b1, 1'b0, 1'b0, 3'd1, 32'h0, 32'h4000, 5'd4, 1'b1, 32'h600);
    valid = 1'b1;
    step();
    addr_ok = 1'b1;
    #1;
    check("drn_req", 32'(req), 1);
    step();
    addr_ok = 1'b0; valid = 1'b0;
    #1;
    check("drn_wait_req", 32'(req), 0);
    step();
    bus = mk_bus(1'b1, 1'b0, 1'b0, 3'd4, 32'h0, 32'h5002, 5'd5, 1'b1, 32'h604);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rdata = $urandom;
      #1;
      check("drn_noreq", 32'(req), 0);
      check("drn_noover", 32'(over), 0);
      step();
    end
    data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    check("drn_discard_over", 32'(over), 0);
    check("drn_discard_req", 32'(req), 0);
    step();
    data_ok = 1'b0;
    do_mem("drn_next", 1'b1, 1'b0, 3'd4, 32'h5002, 32'h0, 32'h00AB_0000, 1, 0, 1'b0, s, d, r);
    check("drn_next_lit", r, 32'h0000_00AB);

    // Asynchronous reset while REQ: request drops before any clock edge
    bus = mk_bus(1'b1, 1'b0, 1'b1, 3'd2, 32'h0, 32'h7006, 5'd6, 1'b1, 32'h700);
    valid = 1'b1;
    step();
    #1;
    check("rstreq_req_before", 32'(req), 1);
    rst_n = 1'b0; valid = 1'b0;
    #1;
    check("rstreq_req_drop", 32'(req), 0);
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset in WAIT; the late response is ignored
    valid = 1'b1;
    step();
    addr_ok = 1'b1;
    step();
    addr_ok = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rstwait_req", 32'(req), 0);
    check("rstwait_over", 32'(over), 0);
    step();
    rst_n = 1'b1; valid = 1'b0;
    data_ok = 1'b1; rdata = $urandom;
    #1;
    check("rstwait_late_over", 32'(over), 0);
    check("rstwait_late_req", 32'(req), 0);
    step();
    data_ok = 1'b0;
    do_mem("rstwait_next", 1'b1, 1'b1, 3'd2, 32'h7006, 32'h0, 32'h8001_0000, 0, 0, 1'b0, s, d, r);
    check("rstwait_next_lit", r, 32'hFFFF_8001);

    // Randomized loads and stores
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 2))
        0:       sz = 3'd4;
        1:       sz = 3'd2;
        default: sz = 3'd1;
      endcase
      do_mem("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, $urandom,
             $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), s, d, r);
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
